// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_LANES  = 4;

  typedef enum logic {INIT, READY} dmem_state_e;

  typedef struct packed {
    logic                   we;
    logic                   byte_acc;
    logic [DMEM_DATA_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_s;

  // One-hot byte enable for a lane index.
  function automatic logic [DMEM_LANES-1:0] lane_mask(input logic [1:0] lane);
    return DMEM_LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the execute stage (master) and the data memory (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  dmem_req_s              req;
  logic                   resp_valid;
  logic                   resp_yumi;
  logic [DMEM_DATA_W-1:0] resp_data;
  logic                   resp_err;

  modport master (
    output req_valid, req, resp_yumi,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req, resp_yumi,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/dmem_responder_bank.sv
// Word-organised storage: one byte-enabled write port, one combinational read port.
module dmem_bank
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DMEM_LANES-1:0]  be,
  input  logic [DMEM_DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [DMEM_DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DMEM_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < int'(DMEM_LANES); l++) begin
        if (be[l]) mem[waddr][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clears storage after reset, then serves LW/LBU/SW/SB through a
// one-entry response buffer. Define DMEM_ERR_EN to flag misaligned / out-of-range accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  dmem_state_e            state;
  logic [ADDR_W-1:0]      init_cnt;
  logic                   resp_valid;
  logic [DMEM_DATA_W-1:0] resp_data;
  logic                   resp_err;

  logic                   ready_c;
  logic                   accept_c;
  logic                   err_c;
  logic [ADDR_W-1:0]      idx_c;
  logic [1:0]             lane_c;
  logic [DMEM_DATA_W-1:0] rword_c;
  logic [DMEM_DATA_W-1:0] ldata_c;
  logic                   mem_we_c;
  logic [ADDR_W-1:0]      mem_waddr_c;
  logic [DMEM_LANES-1:0]  mem_be_c;
  logic [DMEM_DATA_W-1:0] mem_wdata_c;

  // A new request fits when the buffer is empty or being drained this cycle.
  assign ready_c  = (state == READY) & (~resp_valid | bus.resp_yumi);
  assign accept_c = bus.req_valid & ready_c;
  assign idx_c    = bus.req.addr[ADDR_W+1:2];
  assign lane_c   = bus.req.addr[1:0];

`ifdef DMEM_ERR_EN
  assign err_c = (~bus.req.byte_acc & (lane_c != 2'b00)) | (|bus.req.addr[DMEM_DATA_W-1:ADDR_W+2]);
`else
  logic unused_hi_addr;
  assign err_c          = 1'b0;
  assign unused_hi_addr = ^bus.req.addr[DMEM_DATA_W-1:ADDR_W+2];
`endif

  always_comb begin
    ldata_c = rword_c;
    if (bus.req.byte_acc) begin
      case (lane_c)
        2'd0:    ldata_c = {24'b0, rword_c[7:0]};
        2'd1:    ldata_c = {24'b0, rword_c[15:8]};
        2'd2:    ldata_c = {24'b0, rword_c[23:16]};
        default: ldata_c = {24'b0, rword_c[31:24]};
      endcase
    end
  end

  // INIT owns the write port to clear memory; afterwards only accepted, error-free stores write.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = idx_c;
    mem_be_c    = '1;
    mem_wdata_c = bus.req.wdata;
    if (state == INIT) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = init_cnt;
      mem_wdata_c = '0;
    end else begin
      mem_we_c = accept_c & bus.req.we & ~err_c;
      if (bus.req.byte_acc) begin
        mem_be_c    = lane_mask(lane_c);
        mem_wdata_c = {DMEM_LANES{bus.req.wdata[7:0]}};
      end
    end
  end

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (mem_waddr_c),
    .be    (mem_be_c),
    .wdata (mem_wdata_c),
    .raddr (idx_c),
    .rdata (rword_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + ADDR_W'(1);
          if (init_cnt == '1) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (accept_c) begin
      resp_valid <= 1'b1;
      resp_data  <= (bus.req.we | err_c) ? '0 : ldata_c;
      resp_err   <= err_c;
    end else if (bus.resp_yumi) begin
      resp_valid <= 1'b0;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.resp_err   = resp_err;

endmodule
